spatz_vlsu_load_packer: RTL
===========================

Name: spatz_vlsu_load_packer

Overview:
- Load write-back stage directly downstream of the VLSU memory-result interface.
- Consumes per-element memory result words for one vector load command.
- Packs them into full VRF-width lines and issues VRF writes with byte enables, holding each write until the VRF acknowledges it.
- Signals completion so the VLSU can retire the load.

Parameters:
- ELEN, 32, memory result word width in bits; must be a multiple of 8.
- VRF_WIDTH, 128, VRF write data width in bits; must be an integer multiple of ELEN.
- VREG_ADDR_W, 5, VRF line address width.
- VL_W, 16, width of the element-count field.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active low
- cmd_valid_i  in  1  new load command valid
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i
- cmd_vd_i  in  VREG_ADDR_W  first destination VRF line
- cmd_vl_i  in  VL_W  number of ELEN-bit elements to write
- mem_result_valid_i  in  1  memory result word valid
- mem_result_ready_o  out  1  packer accepts result word
- mem_result_rdata_i  in  ELEN  result word
- vrf_waddr_o  out  VREG_ADDR_W  VRF write line address
- vrf_wdata_o  out  VRF_WIDTH  VRF write data
- vrf_we_o  out  1  VRF write request
- vrf_wbe_o  out  VRF_WIDTH/8  VRF byte enables
- vrf_wvalid_i  in  1  VRF write accepted this cycle
- done_o  out  1  one-cycle pulse: command fully written back

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values: all outputs 0 except cmd_ready_o=1. FSM=IDLE; line buffer, lane counter, line counter and remaining count cleared.
- Lane count: LANES = VRF_WIDTH/ELEN. Lane k occupies bits [k*ELEN +: ELEN]; lane 0 is in the LSBs.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch vd and vl, clear buffer/lane/line counters.
  - vl==0 -> DONE; otherwise -> FILL.
  - cmd_ready_o=0 in every other state.
- FILL:
  - mem_result_ready_o=1. On a handshake, write the word into lane[lane_cnt], set that lane's byte-enable bits, lane_cnt++, remaining--.
  - If lane_cnt reaches LANES or remaining reaches 0 on this handshake -> WRITE next cycle.
  - mem_result_ready_o=0 outside FILL; results are never dropped, upstream holds them.
- WRITE:
  - vrf_we_o=1, vrf_waddr_o=vd+line_cnt (mod 2^VREG_ADDR_W, wraps silently).
  - vrf_wdata_o = buffer, with unfilled lanes driven 0; vrf_wbe_o = accumulated enables.
  - All write outputs stay stable until vrf_wvalid_i.
  - On vrf_wvalid_i: line_cnt++, clear buffer/enables/lane_cnt. remaining==0 -> DONE, else -> FILL.
  - vrf_wvalid_i while not in WRITE is ignored.
- DONE: done_o=1 for exactly one cycle -> IDLE. A new command cannot be accepted before IDLE, so there are at least 2 cycles between done_o and the next command's first write.
- Latency:
  - First result is accepted 1 cycle after command accept.
  - A line write is presented 1 cycle after its last word is accepted.
  - done_o is asserted 1 cycle after the final vrf_wvalid_i.
  - No overlap between filling and writing; peak throughput is LANES words per LANES+1 cycles.
- Remaining counter: VL_W bits, never underflows, since FILL exits at 0.
- Reset mid-operation: immediate return to IDLE. Partial line is discarded, no write and no done_o.

Test Plan:
- Single full line: vd=3, vl=4, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back, vrf_wvalid_i=1 -> one write: waddr=3, wdata=0x44444444_33333333_22222222_11111111, wbe=0xFFFF; done_o pulses 1 cycle after the write.
- Partial tail: vd=0, vl=6, words 1..6:
  - write 1: waddr=0, wbe=0xFFFF.
  - write 2: waddr=1, wdata=0x0..0_00000006_00000005, wbe=0x00FF.
  - Exactly 2 writes, one done_o.
- Zero length: vl=0 -> no vrf_we_o, mem_result_ready_o stays 0, done_o pulses 1 cycle after command accept.
- VRF backpressure: vl=4, vrf_wvalid_i low for 5 cycles -> vrf_we_o/waddr/wdata/wbe stable all 5 cycles, mem_result_ready_o=0, cmd_ready_o=0; completes on the 6th cycle.
- Address wrap and sparse input: vd=31, vl=8, mem_result_valid_i toggling every other cycle -> writes to 31 then 0, both wbe=0xFFFF, no lost or duplicated words.
- Reset mid-fill: vl=4, two words accepted, rst_ni low one cycle -> no write, no done_o; cmd_ready_o=1 after reset; a following vl=4 command produces a correct single full-line write.

Source files
------------

// File: rtl/spatz_vlsu_load_packer.sv
// -----------------------------------------------------------------------------
// spatz_vlsu_load_packer
//
// Load write-back stage that sits directly behind the VLSU memory-result
// interface. For one vector load command it collects ELEN-bit result words,
// packs them into VRF_WIDTH-bit lines (lane 0 in the LSBs), and issues one
// VRF write per line with byte enables. Each write is held until the VRF
// acknowledges it. When the last line has been written, done_o pulses for one
// cycle so the VLSU can retire the load.
//
// Filling and writing never overlap. A line therefore costs LANES accept
// cycles plus at least one write cycle.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake; cmd_ready_o is high only in IDLE
//   cmd_vd_i               first destination VRF line
//   cmd_vl_i               number of ELEN-bit elements to write back
//   mem_result_valid_i     result word valid (upstream holds it until accepted)
//   mem_result_ready_o     result word accepted when high with valid
//   mem_result_rdata_i     result word
//   vrf_we_o               VRF write request, held until vrf_wvalid_i
//   vrf_waddr_o            VRF line address, vd + line index (wraps)
//   vrf_wdata_o            packed line, unfilled lanes are zero
//   vrf_wbe_o              byte enables of the filled lanes
//   vrf_wvalid_i           VRF accepted the write this cycle
//   done_o                 one-cycle pulse once the command is written back
// -----------------------------------------------------------------------------
module spatz_vlsu_load_packer #(
   parameter int unsigned ELEN        = 32,
   parameter int unsigned VRF_WIDTH   = 128,
   parameter int unsigned VREG_ADDR_W = 5,
   parameter int unsigned VL_W        = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,

   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [VREG_ADDR_W-1:0]   cmd_vd_i,
   input  logic [VL_W-1:0]          cmd_vl_i,

   input  logic                     mem_result_valid_i,
   output logic                     mem_result_ready_o,
   input  logic [ELEN-1:0]          mem_result_rdata_i,

   output logic [VREG_ADDR_W-1:0]   vrf_waddr_o,
   output logic [VRF_WIDTH-1:0]     vrf_wdata_o,
   output logic                     vrf_we_o,
   output logic [VRF_WIDTH/8-1:0]   vrf_wbe_o,
   input  logic                     vrf_wvalid_i,

   output logic                     done_o
);

   localparam int unsigned LANES      = VRF_WIDTH / ELEN;
   localparam int unsigned LANE_BYTES = ELEN / 8;
   localparam int unsigned VRF_BYTES  = VRF_WIDTH / 8;
   localparam int unsigned LANE_CNT_W = $clog2(LANES + 1);

   localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_e;

   state_e                    state_q;
   state_e                    state_d;

   logic [VREG_ADDR_W-1:0]    vd_q;
   logic [VREG_ADDR_W-1:0]    line_cnt_q;
   logic [VL_W-1:0]           remaining_q;
   logic [LANE_CNT_W-1:0]     lane_cnt_q;
   logic [VRF_WIDTH-1:0]      buffer_q;
   logic [VRF_BYTES-1:0]      be_q;

   logic                      cmd_hs;
   logic                      result_hs;
   logic                      write_hs;
   logic                      line_full;
   logic                      last_word;

   // Handshakes are qualified by state so that stray valids (for example
   // vrf_wvalid_i outside WRITE) have no effect on the datapath.
   assign cmd_hs    = (state_q == IDLE)  && cmd_valid_i;
   assign result_hs = (state_q == FILL)  && mem_result_valid_i;
   assign write_hs  = (state_q == WRITE) && vrf_wvalid_i;

   // A line closes either when its last lane is taken or when the command
   // runs out of elements, whichever comes first.
   assign line_full = (lane_cnt_q == LAST_LANE);
   assign last_word = (remaining_q == VL_W'(1));

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and all outputs. Outputs depend on the state only, so
   // the write request and its address/data/enables are stable for as long as
   // the VRF keeps vrf_wvalid_i low.
   always_comb begin
      state_d            = state_q;
      cmd_ready_o        = 1'b0;
      mem_result_ready_o = 1'b0;
      vrf_we_o           = 1'b0;
      vrf_waddr_o        = '0;
      vrf_wdata_o        = '0;
      vrf_wbe_o          = '0;
      done_o             = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               if (cmd_vl_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = FILL;
               end
            end
         end

         FILL: begin
            mem_result_ready_o = 1'b1;
            if (mem_result_valid_i && (line_full || last_word)) begin
               state_d = WRITE;
            end
         end

         WRITE: begin
            vrf_we_o    = 1'b1;
            vrf_waddr_o = vd_q + line_cnt_q;
            vrf_wdata_o = buffer_q;
            vrf_wbe_o   = be_q;
            if (vrf_wvalid_i) begin
               if (remaining_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = FILL;
               end
            end
         end

         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Command bookkeeping: destination base, elements still to be accepted and
   // the index of the line currently being built. remaining_q cannot
   // underflow because FILL is left as soon as it reaches zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vd_q        <= '0;
         remaining_q <= '0;
         line_cnt_q  <= '0;
      end else begin
         if (cmd_hs) begin
            vd_q        <= cmd_vd_i;
            remaining_q <= cmd_vl_i;
            line_cnt_q  <= '0;
         end
         if (result_hs) begin
            remaining_q <= remaining_q - VL_W'(1);
         end
         if (write_hs) begin
            line_cnt_q <= line_cnt_q + VREG_ADDR_W'(1);
         end
      end
   end

   // Line buffer, byte enables and lane pointer. The buffer is cleared on
   // every new command and after every acknowledged write, which is what makes
   // unfilled tail lanes read as zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buffer_q   <= '0;
         be_q       <= '0;
         lane_cnt_q <= '0;
      end else begin
         if (cmd_hs || write_hs) begin
            buffer_q   <= '0;
            be_q       <= '0;
            lane_cnt_q <= '0;
         end else if (result_hs) begin
            for (int k = 0; k < LANES; k++) begin
               if (lane_cnt_q == LANE_CNT_W'(k)) begin
                  buffer_q[k*ELEN +: ELEN]         <= mem_result_rdata_i;
                  be_q[k*LANE_BYTES +: LANE_BYTES] <= '1;
               end
            end
            lane_cnt_q <= lane_cnt_q + LANE_CNT_W'(1);
         end
      end
   end

endmodule
